// File: rtl/instr_fetch.sv
// Instruction-fetch front end: owns the PC, drives a combinational
// instruction ROM and buffers {pc, instr} pairs in a small FIFO that
// feeds the IF/ID boundary through a valid/stall handshake.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 14,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [31:0]       branch_pc_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_ce_o,
    input  logic [31:0]       rom_instr_i,
    output logic              if_valid_o,
    output logic [31:0]       if_pc_o,
    output logic [31:0]       if_instr_o
);

    // DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [31:0]      pc;
    logic [31:0]      fifo_pc    [DEPTH];
    logic [31:0]      fifo_instr [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic valid;
    logic full;
    logic pop;
    logic push;

    // Handshake: a fetch happens whenever there is room, counting the
    // slot freed by a pop in the same cycle; reset and redirect suppress it.
    always_comb begin
        valid = (count != '0);
        full  = (count == FULL_COUNT);
        pop   = valid & ~stall_i;
        push  = ~rst & ~flush_i & (~full | pop);
    end

    assign rom_ce_o   = push;
    assign rom_addr_o = pc[ADDR_W-1:0];

    // Head-of-FIFO presentation; outputs are forced to zero when empty.
    always_comb begin
        if_valid_o = valid;
        if_pc_o    = '0;
        if_instr_o = '0;
        if (valid) begin
            if_pc_o    = fifo_pc[rd_ptr];
            if_instr_o = fifo_instr[rd_ptr];
        end
    end

    // PC, pointers and occupancy; reset beats redirect, redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            pc     <= branch_pc_i & ~32'd3;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= pc;
            fifo_instr[wr_ptr] <= rom_instr_i;
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch front end of the RISC-V pipeline. It owns the program counter, drives the address and chip-enable of the combinational instruction ROM, and captures each returned word together with its PC in a small FIFO. The FIFO feeds the IF/ID boundary through a valid/stall handshake. Branch and jump redirects from later stages flush the FIFO and restart fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded by reset.
- ADDR_W, 14, ROM byte-address width (`InstrMemNumLog2+2`).
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- stall_i  in  1  downstream not ready; head entry must be held.
- flush_i  in  1  redirect request; discard FIFO and load branch_pc_i.
- branch_pc_i  in  32  redirect target byte address.
- rom_addr_o  out  ADDR_W  ROM byte address, equal to pc[ADDR_W-1:0].
- rom_ce_o  out  1  ROM chip enable; a fetch happens in every cycle where this is 1.
- rom_instr_i  in  32  ROM data, valid in the same cycle as rom_addr_o (combinational ROM).
- if_valid_o  out  1  head entry valid.
- if_pc_o  out  32  PC of head entry; 0 when if_valid_o=0.
- if_instr_o  out  32  instruction of head entry; 0 when if_valid_o=0.

## Operation
- State: pc (32b), FIFO of DEPTH × {pc, instr}, read pointer, write pointer, count (log2(DEPTH)+1 bits).
- pop = if_valid_o & ~stall_i.
- full = (count == DEPTH).
- rom_ce_o = ~rst & ~flush_i & (~full | pop). rom_ce_o is combinational and is 0 during any reset cycle.
- push = rom_ce_o. On push, write {pc, rom_instr_i} at the write pointer, then pc <= pc + 4.
- pc arithmetic is 32-bit modulo 2^32. rom_addr_o truncates pc to ADDR_W bits, so the ROM address wraps.
- Addresses past the programmed ROM image return 0. The fetch unit passes 0 through as an ordinary instruction and does not filter it.
- Priority order, highest first: rst, flush_i, then push/pop.
- rst: pc <= RESET_PC; pointers and count <= 0. Outputs are then if_valid_o=0, if_pc_o=0, if_instr_o=0.
- flush_i: pointers and count <= 0; pc <= {branch_pc_i[31:2], 2'b00}, so misaligned targets are silently aligned. No push occurs that cycle, and a pop that cycle is discarded.
- Push and pop in the same cycle: count is unchanged. This is legal when full (the popped slot is reused) and when count=1.
- Empty FIFO: there is no bypass. A fetched word reaches if_valid_o on the cycle after the fetch.
- Pointers wrap modulo DEPTH.
- stall_i with if_valid_o=0 has no effect.

## Timing
- Fetch-to-output latency: 1 cycle. Word fetched in cycle N is presented in cycle N+1.
- Throughput: 1 instruction/cycle sustained while stall_i=0.
- After reset: rst=1 sampled at edge E. At E+0 (the cycle following E) rom_ce_o=1 and rom_addr_o=RESET_PC. At E+1, if_valid_o=1 with if_pc_o=RESET_PC.
- Redirect: flush_i sampled at edge F. The cycle after F fetches the target. Two cycles after F, if_valid_o=1 with if_pc_o=target. Flush costs exactly one bubble relative to the fetch cycle.
- Continuous stall: the FIFO fills in DEPTH cycles, then rom_ce_o=0 and pc holds.
- Stall release: the head pops immediately and fetch resumes in that same cycle, with no gap in if_valid_o.
- Outputs are driven from registers only: the FIFO head. There is no combinational path from rom_instr_i to if_*_o.

## Test plan
- Reset/stream: ROM holds 0xffe18113 @0x0, 0xfff18a13 @0x4, 0x00318a93 @0x8. Release rst with stall_i=0 -> valid pcs 0x0, 0x4, 0x8 on consecutive cycles with those words; no gaps.
- Back-pressure: hold stall_i=1 from reset -> fetches 0x0 and 0x4, then rom_ce_o=0 with rom_addr_o=0x8 and if_pc_o=0x0 held. Release stall -> output 0x0, 0x4, 0x8 back-to-back.
- Redirect: flush_i with branch_pc_i=0xa0 mid-stream -> exactly one bubble cycle, then if_pc_o=0xa0 and if_instr_o=0x00218293. No pre-flush entry reappears.
- Flush while full and stalled, plus misaligned target 0x96 -> FIFO emptied; next valid if_pc_o=0x94 with if_instr_o=0x0a028367.
- Reset mid-operation while full: assert rst for one cycle -> if_valid_o=0 and outputs=0 next cycle; restart at RESET_PC; no stale entries.
- End of image: run to pc 0xa8 -> if_instr_o=0x00000000 with if_valid_o=1. Also start from pc=0x3ffc -> rom_addr_o wraps to 0x0000 while if_pc_o=0x4000.
